// File: rtl/core_op_dispatcher.sv
// -----------------------------------------------------------------------------
// core_op_dispatcher
//
// Purpose:
//   Sequencer in front of the ECC Core_Implementation datapath. It accepts one
//   field operation at a time and drives the core select line and operands from
//   registers. It then waits the latency of the selected operation, captures the
//   core outputs into a result register, and holds that result until the
//   downstream side takes it.
//
// Ports:
//   clk, rst            single rising-edge clock, asynchronous active-high reset
//   op_valid/op_ready   request handshake (op_ready is high only while idle)
//   op_code             1=MUL 2=SQR 3=XOR 4=LUT 5=MASK, any other code is illegal
//   op_a, op_b          256-bit operands
//   core_sel            select line to the core (0 when no operation is active)
//   core_a, core_b      registered operands to the core
//   core_c, core_d      128-bit core results (may contain undriven bits)
//   res_valid/res_ready result handshake
//   res_c, res_d        captured results
//   res_op              op_code of the held result
//   err                 one-cycle pulse after an illegal op_code is accepted
// -----------------------------------------------------------------------------
module core_op_dispatcher #(
   parameter int MUL_LAT  = 4,
   parameter int COMB_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         op_valid,
   output logic         op_ready,
   input  logic [3:0]   op_code,
   input  logic [255:0] op_a,
   input  logic [255:0] op_b,
   output logic [3:0]   core_sel,
   output logic [255:0] core_a,
   output logic [255:0] core_b,
   input  logic [127:0] core_c,
   input  logic [127:0] core_d,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [127:0] res_c,
   output logic [127:0] res_d,
   output logic [3:0]   res_op,
   output logic         err
);

   // A latency of 0 would mean capturing before the core was ever selected.
   localparam int MUL_LAT_E  = (MUL_LAT  < 1) ? 1 : MUL_LAT;
   localparam int COMB_LAT_E = (COMB_LAT < 1) ? 1 : COMB_LAT;
   localparam int MAX_LAT    = (MUL_LAT_E > COMB_LAT_E) ? MUL_LAT_E : COMB_LAT_E;
   localparam int CNT_W      = $clog2(MAX_LAT + 1);

   localparam logic [3:0] OP_MUL  = 4'd1;
   localparam logic [3:0] OP_MASK = 4'd5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             legal_op;
   logic             accept;
   logic             capture;
   logic             release_res;

   assign legal_op = (op_code >= OP_MUL) && (op_code <= OP_MASK);
   assign op_ready = (state_q == S_IDLE);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments in clocked blocks so that every register
      // samples the values from before the edge, whatever the block order.
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and control strobes
   always_comb begin
      // NOTE: every output gets a default first; a path that leaves one
      // unassigned would infer a latch.
      state_d     = state_q;
      accept      = 1'b0;
      capture     = 1'b0;
      release_res = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (op_valid) begin
               accept = 1'b1;
               // An illegal code is consumed but never reaches the core.
               if (legal_op) begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == CNT_W'(1)) begin
               capture = 1'b1;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (res_ready) begin
               release_res = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         core_sel  <= '0;
         core_a    <= '0;
         core_b    <= '0;
         res_valid <= 1'b0;
         res_c     <= '0;
         res_d     <= '0;
         res_op    <= '0;
         err       <= 1'b0;
      end else begin
         err <= accept && !legal_op;

         if (accept && legal_op) begin
            core_sel <= op_code;
            core_a   <= op_a;
            core_b   <= op_b;
            cnt_q    <= (op_code == OP_MUL) ? CNT_W'(MUL_LAT_E) : CNT_W'(COMB_LAT_E);
         end

         if (state_q == S_WAIT) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end

         if (capture) begin
            res_valid <= 1'b1;
            res_op    <= core_sel;
            core_sel  <= '0;   // operands stay put, only the select is dropped
            if (core_sel == OP_MASK) begin
               // The core leaves C and the top of D undriven for MASK; keep
               // those bits from ever reaching the result.
               res_c <= '0;
               res_d <= {64'd0, core_d[63:0]};
            end else begin
               res_c <= core_c;
               res_d <= core_d;
            end
         end

         if (release_res) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_core_op_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_core_op_dispatcher
//
// Directed bench for core_op_dispatcher with MUL_LAT=4, COMB_LAT=1. A small
// behavioural stand-in for the core sits on core_c/core_d: XOR of the halves,
// carry-less multiply/square of the low halves, and MASK with C and D[127:64]
// left X. The MUL product stays X until core_sel has been MUL for MUL_LAT
// cycles, so an early capture shows up as X in the result.
// -----------------------------------------------------------------------------
module tb_core_op_dispatcher;

   localparam int MUL_LAT  = 4;
   localparam int COMB_LAT = 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         op_valid;
   logic         op_ready;
   logic [3:0]   op_code;
   logic [255:0] op_a;
   logic [255:0] op_b;
   logic [3:0]   core_sel;
   logic [255:0] core_a;
   logic [255:0] core_b;
   logic [127:0] core_c;
   logic [127:0] core_d;
   logic         res_valid;
   logic         res_ready;
   logic [127:0] res_c;
   logic [127:0] res_d;
   logic [3:0]   res_op;
   logic         err;

   int n_vec = 0;
   int n_bad = 0;
   int mul_cyc = 0;

   core_op_dispatcher #(
      .MUL_LAT  (MUL_LAT),
      .COMB_LAT (COMB_LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_code   (op_code),
      .op_a      (op_a),
      .op_b      (op_b),
      .core_sel  (core_sel),
      .core_a    (core_a),
      .core_b    (core_b),
      .core_c    (core_c),
      .core_d    (core_d),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_c     (res_c),
      .res_d     (res_d),
      .res_op    (res_op),
      .err       (err)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] clmul(input logic [127:0] x, input logic [127:0] y);
      logic [255:0] acc;
      acc = '0;
      for (int i = 0; i < 128; i++) begin
         if (y[i]) acc = acc ^ ({128'd0, x} << i);
      end
      return acc;
   endfunction

   // Cycles the core has spent with MUL selected.
   always @(posedge clk) begin
      mul_cyc <= (core_sel == 4'd1) ? mul_cyc + 1 : 0;
   end

   always_comb begin
      core_c = 'x;
      core_d = 'x;
      case (core_sel)
         4'd1: if (mul_cyc >= MUL_LAT - 1) {core_c, core_d} = clmul(core_a[127:0], core_b[127:0]);
         4'd2: {core_c, core_d} = clmul(core_a[127:0], core_a[127:0]);
         4'd3: begin
            core_c = core_a[255:128] ^ core_b[255:128];
            core_d = core_a[127:0] ^ core_b[127:0];
         end
         4'd5: core_d[63:0] = core_a[63:0] & core_b[63:0];
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expd);
      n_vec++;
      assert (obs === expd) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expd);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_op(input logic [3:0] code, input logic [255:0] a, input logic [255:0] b);
      op_valid = 1'b1;
      op_code  = code;
      op_a     = a;
      op_b     = b;
   endtask

   initial begin
      rst       = 1'b1;
      op_valid  = 1'b0;
      op_code   = '0;
      op_a      = '0;
      op_b      = '0;
      res_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset state
      check("rst_op_ready",  op_ready,  1);
      check("rst_res_valid", res_valid, 0);
      check("rst_err",       err,       0);
      check("rst_core_sel",  core_sel,  0);
      check("rst_core_a",    core_a,    0);
      check("rst_res_c",     res_c,     0);
      check("rst_res_d",     res_d,     0);
      check("rst_res_op",    res_op,    0);

      // XOR: result one cycle after accept
      drive_op(4'd3, {128'h1, 128'hF0}, {128'h3, 128'h0F});
      step();
      op_valid = 1'b0;
      check("xor_core_sel", core_sel, 3);
      check("xor_core_a",   core_a,   {128'h1, 128'hF0});
      check("xor_op_ready", op_ready, 0);
      check("xor_rv_early", res_valid, 0);
      step();
      check("xor_res_valid", res_valid, 1);
      check("xor_res_c",     res_c,     128'h2);
      check("xor_res_d",     res_d,     128'hFF);
      check("xor_res_op",    res_op,    3);
      check("xor_sel_clr",   core_sel,  0);
      check("xor_core_b",    core_b,    {128'h3, 128'h0F});
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check("xor_rv_drop",  res_valid, 0);
      check("xor_ready_up", op_ready,  1);

      // MUL: four cycles of WAIT with core_sel=MUL; res_ready during WAIT is ignored
      drive_op(4'd1, 256'h2, 256'h3);
      step();
      op_valid  = 1'b0;
      res_ready = 1'b1;
      for (int i = 0; i < MUL_LAT; i++) begin
         check("mul_sel_wait", core_sel,  1);
         check("mul_rv_wait",  res_valid, 0);
         check("mul_ready_wait", op_ready, 0);
         step();
      end
      check("mul_res_valid", res_valid, 1);
      check("mul_res_c",     res_c,     0);
      check("mul_res_d",     res_d,     128'h6);
      check("mul_res_op",    res_op,    1);
      check("mul_sel_clr",   core_sel,  0);
      step();
      res_ready = 1'b0;
      check("mul_rv_drop",  res_valid, 0);
      check("mul_ready_up", op_ready,  1);

      // SQR: (x+1)^2 = x^2+1 over GF(2)
      drive_op(4'd2, 256'h3, 256'h0);
      step();
      op_valid = 1'b0;
      step();
      check("sqr_res_valid", res_valid, 1);
      check("sqr_res_c",     res_c,     0);
      check("sqr_res_d",     res_d,     128'h5);
      check("sqr_res_op",    res_op,    2);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check("sqr_rv_drop", res_valid, 0);

      // MASK with undriven C and D[127:64], then 10 cycles of backpressure
      drive_op(4'd5, {128'h0, 128'hAAAA_BBBB_CCCC_DDDD_1234_5678_9ABC_DEF0},
                     {128'h0, 128'h0000_0000_0000_0000_FFFF_0000_FFFF_00FF});
      step();
      step();
      check("mask_res_valid", res_valid, 1);
      check("mask_res_c",     res_c,     0);
      check("mask_res_d",     res_d,     {64'h0, 64'h1234_0000_9ABC_00F0});
      check("mask_res_op",    res_op,    5);
      // A new request during HOLD must be ignored.
      drive_op(4'd2, 256'h7, 256'h7);
      for (int i = 0; i < 10; i++) begin
         step();
         check("bp_res_valid", res_valid, 1);
         check("bp_res_c",     res_c,     0);
         check("bp_res_d",     res_d,     {64'h0, 64'h1234_0000_9ABC_00F0});
         check("bp_res_op",    res_op,    5);
         check("bp_op_ready",  op_ready,  0);
         check("bp_core_sel",  core_sel,  0);
      end
      op_valid  = 1'b0;
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check("bp_rv_drop",  res_valid, 0);
      check("bp_ready_up", op_ready,  1);

      // Illegal op_code 7: err for exactly one cycle, no result
      drive_op(4'd7, 256'h1, 256'h1);
      check("ill_ready_pre", op_ready, 1);
      step();
      op_valid = 1'b0;
      check("ill_err",      err,       1);
      check("ill_core_sel", core_sel,  0);
      check("ill_op_ready", op_ready,  1);
      check("ill_rv",       res_valid, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("ill_err_low", err,       0);
         check("ill_rv_low",  res_valid, 0);
         check("ill_ready",   op_ready,  1);
      end

      // Illegal op_code 0 and 6 sit just outside the legal range
      drive_op(4'd0, 256'h0, 256'h0);
      step();
      op_valid = 1'b0;
      check("ill0_err",      err,      1);
      check("ill0_core_sel", core_sel, 0);
      drive_op(4'd6, 256'h0, 256'h0);
      step();
      op_valid = 1'b0;
      check("ill6_err",      err,      1);
      check("ill6_core_sel", core_sel, 0);
      step();
      check("ill6_err_low",  err,       0);
      check("ill6_rv",       res_valid, 0);

      // Reset two cycles into a MUL
      drive_op(4'd1, 256'h2, 256'h3);
      step();
      op_valid = 1'b0;
      step();
      step();
      check("rmul_sel_active", core_sel, 1);
      rst = 1'b1;
      #1;
      check("rmul_core_sel",  core_sel,  0);
      check("rmul_core_a",    core_a,    0);
      check("rmul_core_b",    core_b,    0);
      check("rmul_res_valid", res_valid, 0);
      check("rmul_err",       err,       0);
      check("rmul_op_ready",  op_ready,  1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      res_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         check("rmul_no_rv",    res_valid, 0);
         check("rmul_no_err",   err,       0);
         check("rmul_ready",    op_ready,  1);
         check("rmul_sel_idle", core_sel,  0);
      end
      check("rmul_res_d", res_d, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
